unit_arbiter: RTL and testbench

UNIT_ARBITER -- requirements
Module: unit_arbiter

---
 rtl/unit_arbiter_pkg.sv | 19 +
 rtl/unit_arbiter_dec.sv | 20 ++
 rtl/unit_arbiter.sv | 138 +++++++++++++
 tb/tb_unit_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/unit_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : unit_arbiter_pkg
// Description : Shared FSM state type and default requester count for the
//               POSIT-unit round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package unit_arbiter_pkg;

    localparam int C_NREQ_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage : unit_arbiter_pkg
`default_nettype wire

// File: rtl/unit_arbiter_dec.sv
`default_nettype none
// ============================================================================
// Module      : unit_arbiter_dec
// Description : MSB-first index decoder; index i lights bit BITS-1-i.
// Revision    : 1.0 - initial release
// ============================================================================
module unit_arbiter_dec #(
    parameter int BITS  = 8,
    parameter int IDX_W = $clog2(BITS)
) (
    input  logic [IDX_W-1:0] idx,
    output logic [BITS-1:0]  onehot
);

    for (genvar b = 0; b < BITS; b++) begin : g_bit
        assign onehot[b] = (idx == IDX_W'(BITS - 1 - b));
    end

endmodule : unit_arbiter_dec
`default_nettype wire

// File: rtl/unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unit_arbiter
// Description : Round-robin arbiter granting one shared POSIT unit to NREQ
//               requesters; fully registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module unit_arbiter
    import unit_arbiter_pkg::*;
#(
    parameter int NREQ  = C_NREQ_DEFAULT,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             unit_done,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             unit_start,
    output logic [NREQ-1:0]  req_done,
    output logic             busy,
    output logic             spurious_done
);

    state_t            r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [NREQ-1:0]   r_grant;
    logic [IDX_W-1:0]  r_grant_idx;
    logic              r_unit_start;
    logic [NREQ-1:0]   r_req_done;
    logic              r_busy;
    logic              r_spurious;

    state_t            w_state_next;
    logic [IDX_W-1:0]  w_ptr_next;
    logic [NREQ-1:0]   w_grant_next;
    logic [IDX_W-1:0]  w_grant_idx_next;
    logic              w_unit_start_next;
    logic [NREQ-1:0]   w_req_done_next;
    logic              w_busy_next;
    logic              w_spurious_next;

    logic [IDX_W-1:0]  w_winner;
    logic [IDX_W-1:0]  w_cand;
    logic              w_found;
    logic [NREQ-1:0]   w_winner_onehot;

    // Search starts at ptr; IDX_W-bit addition provides the wrap to 0.
    always_comb begin
        w_winner = '0;
        w_cand   = '0;
        w_found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = r_ptr + IDX_W'(k);
            if (!w_found && req[w_cand]) begin
                w_winner = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    unit_arbiter_dec #(
        .BITS (NREQ)
    ) u_dec (
        .idx    (w_winner),
        .onehot (w_winner_onehot)
    );

    always_comb begin
        w_state_next      = r_state;
        w_ptr_next        = r_ptr;
        w_grant_next      = r_grant;
        w_grant_idx_next  = r_grant_idx;
        w_unit_start_next = 1'b0;
        w_req_done_next   = '0;
        w_spurious_next   = r_spurious;
        case (r_state)
            ST_IDLE: begin
                if (unit_done) begin
                    w_spurious_next = 1'b1;
                end
                if (|req) begin
                    w_state_next      = ST_ISSUE;
                    w_grant_idx_next  = w_winner;
                    w_grant_next      = w_winner_onehot;
                    w_ptr_next        = w_winner + IDX_W'(1);
                    w_unit_start_next = 1'b1;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (unit_done) begin
                    w_state_next    = ST_IDLE;
                    w_req_done_next = r_grant;
                    w_grant_next    = '0;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_grant_next = '0;
            end
        endcase
        w_busy_next = (w_state_next != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_grant      <= '0;
            r_grant_idx  <= '0;
            r_unit_start <= 1'b0;
            r_req_done   <= '0;
            r_busy       <= 1'b0;
            r_spurious   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ptr        <= w_ptr_next;
            r_grant      <= w_grant_next;
            r_grant_idx  <= w_grant_idx_next;
            r_unit_start <= w_unit_start_next;
            r_req_done   <= w_req_done_next;
            r_busy       <= w_busy_next;
            r_spurious   <= w_spurious_next;
        end
    end

    assign grant         = r_grant;
    assign grant_idx     = r_grant_idx;
    assign unit_start    = r_unit_start;
    assign req_done      = r_req_done;
    assign busy          = r_busy;
    assign spurious_done = r_spurious;

endmodule : unit_arbiter
`default_nettype wire

// File: tb/tb_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_unit_arbiter
// Description : Directed self-checking bench for unit_arbiter (NREQ=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unit_arbiter;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst;
    logic [NREQ-1:0]  req;
    logic             unit_done;
    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             unit_start;
    logic [NREQ-1:0]  req_done;
    logic             busy;
    logic             spurious_done;

    int n_checks;
    int n_errors;

    unit_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .unit_done     (unit_done),
        .grant         (grant),
        .grant_idx     (grant_idx),
        .unit_start    (unit_start),
        .req_done      (req_done),
        .busy          (busy),
        .spurious_done (spurious_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full output snapshot: grant, grant_idx, unit_start, req_done, busy.
    task automatic chk_outs(input string tag, input logic [7:0] e_grant, input logic [2:0] e_idx,
                            input logic e_start, input logic [7:0] e_done, input logic e_busy);
        chk_value({tag, ".grant"},      32'(grant),      32'(e_grant));
        chk_value({tag, ".grant_idx"},  32'(grant_idx),  32'(e_idx));
        chk_value({tag, ".unit_start"}, 32'(unit_start), 32'(e_start));
        chk_value({tag, ".req_done"},   32'(req_done),   32'(e_done));
        chk_value({tag, ".busy"},       32'(busy),       32'(e_busy));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        req       = '0;
        unit_done = 1'b0;
        tick();
        tick();
        chk_outs("reset", 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
        chk_value("reset.spurious", 32'(spurious_done), 32'd0);
        rst = 1'b0;

        // Requesters 0 and 2; ptr starts at 0 so requester 0 wins first.
        req = 8'b0000_0101;
        tick();
        chk_outs("rr0.issue", 8'b1000_0000, 3'd0, 1'b1, 8'h00, 1'b1);
        tick();
        chk_outs("rr0.wait", 8'b1000_0000, 3'd0, 1'b0, 8'h00, 1'b1);
        unit_done = 1'b1;
        tick();
        chk_outs("rr0.done", 8'h00, 3'd0, 1'b0, 8'b1000_0000, 1'b0);
        unit_done = 1'b0;
        tick();
        chk_outs("rr2.issue", 8'b0010_0000, 3'd2, 1'b1, 8'h00, 1'b1);

        // Done in the ISSUE cycle skips WAIT.
        unit_done = 1'b1;
        tick();
        chk_outs("rr2.fastdone", 8'h00, 3'd2, 1'b0, 8'b0010_0000, 1'b0);
        unit_done = 1'b0;
        tick();
        chk_outs("rr0b.issue", 8'b1000_0000, 3'd0, 1'b1, 8'h00, 1'b1);

        // Requester drops mid-operation and still gets its completion pulse.
        req       = '0;
        unit_done = 1'b1;
        tick();
        chk_outs("drop.done", 8'h00, 3'd0, 1'b0, 8'b1000_0000, 1'b0);

        // Stray done while idle: sticky flag, no state change.
        tick();
        chk_value("spur.flag", 32'(spurious_done), 32'd1);
        chk_outs("spur.idle", 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
        unit_done = 1'b0;
        tick();
        tick();
        chk_value("spur.held", 32'(spurious_done), 32'd1);
        chk_outs("idle.quiet", 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);

        // ptr is 1; requester 6 wins and moves ptr to 7.
        req = 8'b0100_0000;
        tick();
        chk_outs("rr6.issue", 8'b0000_0010, 3'd6, 1'b1, 8'h00, 1'b1);
        req       = 8'b1000_0010;
        unit_done = 1'b1;
        tick();
        chk_outs("rr6.done", 8'h00, 3'd6, 1'b0, 8'b0000_0010, 1'b0);
        unit_done = 1'b0;
        tick();
        chk_outs("rr7.issue", 8'b0000_0001, 3'd7, 1'b1, 8'h00, 1'b1);
        unit_done = 1'b1;
        tick();
        chk_outs("rr7.done", 8'h00, 3'd7, 1'b0, 8'b0000_0001, 1'b0);
        unit_done = 1'b0;
        tick();
        chk_outs("wrap1.issue", 8'b0100_0000, 3'd1, 1'b1, 8'h00, 1'b1);
        req       = '0;
        unit_done = 1'b1;
        tick();
        chk_outs("wrap1.done", 8'h00, 3'd1, 1'b0, 8'b0100_0000, 1'b0);
        unit_done = 1'b0;
        chk_value("spur.still", 32'(spurious_done), 32'd1);

        // ptr is 2; requester 5 wins, then reset hits in WAIT.
        req = 8'b0010_0000;
        tick();
        chk_outs("rr5.issue", 8'b0000_0100, 3'd5, 1'b1, 8'h00, 1'b1);
        req = '0;
        tick();
        chk_outs("rr5.wait", 8'b0000_0100, 3'd5, 1'b0, 8'h00, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_outs("async_rst", 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
        chk_value("async_rst.spurious", 32'(spurious_done), 32'd0);
        unit_done = 1'b1;
        tick();
        unit_done = 1'b0;
        rst       = 1'b0;
        tick();
        chk_outs("post_rst", 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);

        // Requesters 5 and 6: ptr restarted at 0 so 5 wins (6 if ptr had survived).
        req = 8'b0110_0000;
        tick();
        chk_outs("rst_ptr.issue", 8'b0000_0100, 3'd5, 1'b1, 8'h00, 1'b1);
        chk_value("rst_ptr.spurious", 32'(spurious_done), 32'd0);
        req = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_unit_arbiter
`default_nettype wire
